// File: rtl/bht.sv
// bht -- fully-associative branch history table with 2-bit saturating counters.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   lk_pc                fetch-stage PC to look up
//   pre_hit              lk_pc matches a valid entry
//   pre_taken            predicted taken (BHT_Pre fetch-mux select term)
//   pre_target           predicted target, zero when pre_taken=0
//   upd_en               one-cycle strobe: a branch resolved this cycle
//   upd_pc/upd_taken/upd_target/upd_mispred  resolved branch information
//   mispred_cnt          saturating count of mispredicting updates
//   entry_cnt            number of valid entries
//
// Update protocol: upd_en is a plain strobe with no ready/backpressure; the
// table accepts every update in the cycle it is presented, and the effect is
// visible from the following cycle. Lookup is purely combinational from
// registered state, so a same-cycle lookup sees the pre-update entry.
module bht #(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 10,
  parameter int TGT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PC_W-1:0]            lk_pc,
  output logic                       pre_taken,
  output logic [TGT_W-1:0]           pre_target,
  output logic                       pre_hit,
  input  logic                       upd_en,
  input  logic [PC_W-1:0]            upd_pc,
  input  logic                       upd_taken,
  input  logic [TGT_W-1:0]           upd_target,
  input  logic                       upd_mispred,
  output logic [15:0]                mispred_cnt,
  output logic [$clog2(ENTRIES):0]   entry_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] validQ;
  logic [PC_W-1:0]    tagQ [ENTRIES];
  logic [TGT_W-1:0]   tgtQ [ENTRIES];
  logic [1:0]         ctrQ [ENTRIES];
  logic [IDX_W-1:0]   rrPtr;
  logic [15:0]        mispredQ;
  logic [IDX_W:0]     entryQ;

  logic               lkHit;
  logic [IDX_W-1:0]   lkIdx;
  logic               updHit;
  logic [IDX_W-1:0]   updIdx;
  logic               anyFree;
  logic [IDX_W-1:0]   freeIdx;
  logic               doAlloc;
  logic [IDX_W-1:0]   allocIdx;

  // Lookup and update match. Tags are unique among valid entries, so at most
  // one index can satisfy each compare and the last-hit-wins loop is exact.
  always_comb begin
    lkHit  = 1'b0;
    lkIdx  = '0;
    updHit = 1'b0;
    updIdx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (validQ[i] && tagQ[i] == lk_pc) begin
        lkHit = 1'b1;
        lkIdx = IDX_W'(i);
      end
      if (validQ[i] && tagQ[i] == upd_pc) begin
        updHit = 1'b1;
        updIdx = IDX_W'(i);
      end
    end
  end

  // Lowest-index invalid entry: scan downward so the lowest index wins.
  always_comb begin
    anyFree = 1'b0;
    freeIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!validQ[i]) begin
        anyFree = 1'b1;
        freeIdx = IDX_W'(i);
      end
    end
  end

  assign doAlloc  = upd_en && !updHit && upd_taken;
  assign allocIdx = anyFree ? freeIdx : rrPtr;

  assign pre_hit    = lkHit;
  assign pre_taken  = lkHit && ctrQ[lkIdx][1];
  assign pre_target = pre_taken ? tgtQ[lkIdx] : '0;

  assign mispred_cnt = mispredQ;
  assign entry_cnt   = entryQ;

  // Control state: valid bits, counters, replacement pointer, statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ   <= '0;
      rrPtr    <= '0;
      mispredQ <= '0;
      entryQ   <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrQ[i] <= 2'b00;
    end else begin
      if (upd_en && upd_mispred && mispredQ != 16'hFFFF)
        mispredQ <= mispredQ + 16'd1;
      if (upd_en && updHit) begin
        if (upd_taken) begin
          if (ctrQ[updIdx] != 2'b11) ctrQ[updIdx] <= ctrQ[updIdx] + 2'd1;
        end else begin
          if (ctrQ[updIdx] != 2'b00) ctrQ[updIdx] <= ctrQ[updIdx] - 2'd1;
        end
      end
      if (doAlloc) begin
        validQ[allocIdx] <= 1'b1;
        ctrQ[allocIdx]   <= 2'b10;
        if (anyFree) entryQ <= entryQ + 1'b1;
        // ENTRIES is a power of two, so natural wrap gives modulo ENTRIES.
        else         rrPtr  <= rrPtr + 1'b1;
      end
    end
  end

  // Tag/target payload is qualified by validQ and needs no reset.
  always_ff @(posedge clk) begin
    if (upd_en && updHit && upd_taken)
      tgtQ[updIdx] <= upd_target;
    if (doAlloc) begin
      tagQ[allocIdx] <= upd_pc;
      tgtQ[allocIdx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_bht.sv
// tb_bht -- directed self-checking bench for bht (ENTRIES=8, PC_W=10, TGT_W=32).
module tb_bht;

  logic        clk;
  logic        rst_n;
  logic [9:0]  lk_pc;
  logic        pre_taken;
  logic [31:0] pre_target;
  logic        pre_hit;
  logic        upd_en;
  logic [9:0]  upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [15:0] mispred_cnt;
  logic [3:0]  entry_cnt;

  int vecCnt = 0;
  int errCnt = 0;

  bht dut (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc),
    .pre_taken(pre_taken), .pre_target(pre_target), .pre_hit(pre_hit),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .mispred_cnt(mispred_cnt), .entry_cnt(entry_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; the update is applied by the following posedge and
  // the task returns at the next negedge with upd_en low.
  task automatic upd(input logic [9:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mp);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispred = mp;
    @(negedge clk);
    upd_en = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic look(input string tag, input logic [9:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    lk_pc = pc;
    #1;
    chk({tag, ".hit"}, {31'd0, pre_hit}, {31'd0, hit});
    chk({tag, ".taken"}, {31'd0, pre_taken}, {31'd0, tk});
    chk({tag, ".target"}, pre_target, tgt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; lk_pc = '0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispred = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    look("rst", 10'h004, 1'b0, 1'b0, 32'h0);
    chk("rst.entry_cnt", 32'(entry_cnt), 32'd0);
    chk("rst.mispred_cnt", 32'(mispred_cnt), 32'd0);

    // First allocation: ctr=2 -> taken
    upd(10'h004, 1'b1, 32'h20, 1'b0);
    look("alloc", 10'h004, 1'b1, 1'b1, 32'h20);
    chk("alloc.entry_cnt", 32'(entry_cnt), 32'd1);

    // Two not-taken: 2->1->0
    upd(10'h004, 1'b0, 32'h0, 1'b0);
    look("nt1", 10'h004, 1'b1, 1'b0, 32'h0);
    upd(10'h004, 1'b0, 32'h0, 1'b0);
    look("nt2", 10'h004, 1'b1, 1'b0, 32'h0);

    // Four taken: 0->1->2->3->3 (saturate), then two not-taken: 3->2->1
    repeat (3) upd(10'h004, 1'b1, 32'h20, 1'b0);
    look("t3", 10'h004, 1'b1, 1'b1, 32'h20);
    upd(10'h004, 1'b1, 32'h20, 1'b0);
    upd(10'h004, 1'b0, 32'h0, 1'b0);
    look("sat.nt", 10'h004, 1'b1, 1'b1, 32'h20);
    upd(10'h004, 1'b0, 32'h0, 1'b0);
    look("sat.nt2", 10'h004, 1'b1, 1'b0, 32'h0);

    // ctr=1; taken with new target overwrites target, ctr -> 2
    upd(10'h004, 1'b1, 32'h44, 1'b1);
    look("retgt", 10'h004, 1'b1, 1'b1, 32'h44);
    chk("retgt.mispred_cnt", 32'(mispred_cnt), 32'd1);

    // Not-taken miss leaves table unchanged; mispred without upd_en ignored
    upd(10'h3FF, 1'b0, 32'h99, 1'b0);
    look("ntmiss", 10'h3FF, 1'b0, 1'b0, 32'h0);
    chk("ntmiss.entry_cnt", 32'(entry_cnt), 32'd1);
    upd_mispred = 1'b1;
    @(negedge clk);
    upd_mispred = 1'b0;
    chk("mpnoen.mispred_cnt", 32'(mispred_cnt), 32'd1);

    // Fill an empty table with 9 PCs: 9th replaces entry 0, rr_ptr -> 1
    do_reset();
    for (int i = 0; i < 9; i++) begin
      upd(10'h100 + 10'(i), 1'b1, 32'h1000 + 32'(i), 1'b0);
      if (i == 7) chk("fill8.entry_cnt", 32'(entry_cnt), 32'd8);
    end
    look("rr.first", 10'h100, 1'b0, 1'b0, 32'h0);
    look("rr.ninth", 10'h108, 1'b1, 1'b1, 32'h1008);
    look("rr.second", 10'h101, 1'b1, 1'b1, 32'h1001);
    chk("rr.entry_cnt", 32'(entry_cnt), 32'd8);
    // 10th allocation must land on entry 1, proving rr_ptr was 1
    upd(10'h109, 1'b1, 32'h1009, 1'b0);
    look("rr2.second", 10'h101, 1'b0, 1'b0, 32'h0);
    look("rr2.third", 10'h102, 1'b1, 1'b1, 32'h1002);
    look("rr2.tenth", 10'h109, 1'b1, 1'b1, 32'h1009);

    // Same-cycle lookup/update on 0x102 with ctr 1->2
    upd(10'h102, 1'b0, 32'h0, 1'b0);
    lk_pc = 10'h102;
    upd_en = 1'b1; upd_pc = 10'h102; upd_taken = 1'b1; upd_target = 32'h1002;
    #1;
    chk("same.taken_before", {31'd0, pre_taken}, 32'd0);
    @(negedge clk);
    upd_en = 1'b0;
    #1;
    chk("same.taken_after", {31'd0, pre_taken}, 32'd1);
    chk("same.target_after", pre_target, 32'h1002);

    // Asynchronous reset in the middle of a mispredicting update
    @(negedge clk);
    upd_en = 1'b1; upd_pc = 10'h102; upd_taken = 1'b0; upd_mispred = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.hit", {31'd0, pre_hit}, 32'd0);
    chk("arst.taken", {31'd0, pre_taken}, 32'd0);
    chk("arst.target", pre_target, 32'h0);
    chk("arst.entry_cnt", 32'(entry_cnt), 32'd0);
    @(negedge clk);
    upd_en = 1'b0; upd_mispred = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("arst.mispred_cnt", 32'(mispred_cnt), 32'd0);

    // 65536+ mispredicting updates saturate at FFFF
    @(negedge clk);
    upd_en = 1'b1; upd_pc = 10'h3FF; upd_taken = 1'b0; upd_mispred = 1'b1;
    repeat (65534) @(negedge clk);
    chk("mp.fffe", 32'(mispred_cnt), 32'h0000FFFE);
    @(negedge clk);
    chk("mp.ffff", 32'(mispred_cnt), 32'h0000FFFF);
    repeat (5) @(negedge clk);
    chk("mp.hold", 32'(mispred_cnt), 32'h0000FFFF);
    chk("mp.entry_cnt", 32'(entry_cnt), 32'd0);
    upd_en = 1'b0; upd_mispred = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/bht.md
BHT -- requirements
Module: bht

Interface
REQ-001 Parameter ENTRIES, default 8: number of fully-associative table entries (power of two, 2..16).
REQ-002 Parameter PC_W, default 10: width of the word-addressed PC.
REQ-003 Parameter TGT_W, default 32: width of the stored branch target.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous and active-low.
REQ-006 lk_pc  in  PC_W: fetch-stage PC to look up.
REQ-007 pre_taken  out  1: prediction result, taken=1; drives the fetch mux select term BHT_Pre.
REQ-008 pre_target  out  TGT_W: predicted branch target; zero when pre_taken=0.
REQ-009 pre_hit  out  1: lk_pc matches a valid entry.
REQ-010 upd_en  in  1: a branch resolved this cycle, one-cycle strobe.
REQ-011 upd_pc  in  PC_W: PC of the resolved branch.
REQ-012 upd_taken  in  1: actual branch outcome.
REQ-013 upd_target  in  TGT_W: actual branch target.
REQ-014 upd_mispred  in  1: the resolving stage flagged a misprediction.
REQ-015 mispred_cnt  out  16: saturating count of misprediction updates.
REQ-016 entry_cnt  out  $clog2(ENTRIES)+1: number of valid entries.

Function
REQ-017 Each entry SHALL hold: valid, tag (PC_W bits), target (TGT_W bits), and a 2-bit saturating counter ctr.
REQ-018 Lookup SHALL be combinational from registered state: pre_hit = any valid entry with tag==lk_pc; pre_taken = pre_hit & ctr[1] of the matching entry.
REQ-019 At most one entry SHALL ever match a given PC; a duplicate allocation is a design error.
REQ-020 On upd_en with a matching entry, the counter SHALL update: taken gives min(ctr+1,3); not-taken gives max(ctr-1,0).
REQ-021 On upd_en with a matching entry and upd_taken=1, the stored target SHALL be overwritten with upd_target.
REQ-022 On upd_en with no match and upd_taken=1, an entry SHALL be allocated with valid=1, tag=upd_pc, target=upd_target, ctr=2'b10.
REQ-023 On upd_en with no match and upd_taken=0, the table SHALL be unchanged.
REQ-024 Allocation victim SHALL be the lowest-index invalid entry; if none is invalid, the entry at round-robin pointer rr_ptr.
REQ-025 rr_ptr SHALL advance by 1, modulo ENTRIES, only on an allocation into a full table.
REQ-026 If lk_pc==upd_pc in the same cycle, the lookup SHALL return the pre-update state; the new state is visible on the next cycle.
REQ-027 mispred_cnt SHALL increment on upd_en&upd_mispred and hold at 16'hFFFF.
REQ-028 upd_mispred without upd_en SHALL be ignored.
REQ-029 entry_cnt SHALL increment on allocation into an invalid entry; it never decrements except on reset.
REQ-030 Update latency: state SHALL change at the rising edge where upd_en=1; no internal pipelining.

Reset
REQ-031 On rst_n=0, asynchronously: all valid=0, ctr=0, rr_ptr=0, mispred_cnt=0, entry_cnt=0; pre_taken=0, pre_hit=0, pre_target=0.
REQ-032 Reset SHALL take priority over a coincident upd_en; the update SHALL be lost.
REQ-033 Tag and target storage need not be cleared on reset.

Verification
REQ-034 Reset, then lk_pc=10'h004 -> pre_hit=0, pre_taken=0, pre_target=0.
REQ-035 upd_en, pc=0x004, taken=1, target=0x20 -> next cycle, lk_pc=0x004 gives pre_hit=1, pre_taken=1, pre_target=0x20, entry_cnt=1.
REQ-036 Then two not-taken updates on 0x004 -> ctr 2->1->0, pre_taken=0, pre_hit=1; three taken updates -> ctr saturates at 3, pre_taken=1.
REQ-037 Allocate 9 distinct taken PCs (ENTRIES=8) -> the 9th replaces entry 0, rr_ptr=1, the first PC misses, entry_cnt=8.
REQ-038 Same-cycle lookup and update on one PC (ctr 1->2) -> pre_taken=0 in that cycle, 1 in the next.
REQ-039 Assert rst_n=0 mid-update with upd_mispred=1 -> all outputs 0 immediately, mispred_cnt=0 after release; 65536 mispredict updates -> mispred_cnt=16'hFFFF and holds.
